io_in_capture_cell: RTL and testbench

- Pad-to-fabric counterpart of the output register cell in the AP3 io_reg group.
- Samples the external pad input on IQC through a synchronizer and an optional glitch filter, then a capture register.
- Drives the fabric with either the captured value or the raw bypass path, selected per cell.
- Generates single-cycle rise/fall event pulses and a sticky edge status flag for fabric polling logic.

---
 rtl/io_in_capture_cell.sv | 76 +++++++
 tb/tb_io_in_capture_cell.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_in_capture_cell.sv
// Pad input capture cell: gated pad -> synchronizer -> glitch filter -> capture register,
// with registered rise/fall event pulses and a sticky edge status flag.
module io_in_capture_cell #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int FILT_W      = 4
) (
    input  logic IQC,
    input  logic QRN,
    input  logic PAD_IN,
    input  logic IE,
    input  logic ISEL,
    input  logic IQE,
    input  logic FILT_EN,
    input  logic CLR,
    output logic A2F_OUT,
    output logic RISE,
    output logic FALL,
    output logic EDGE_STS
);

    logic                   din;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   filt;
    logic                   filt_next;
    logic [FILT_W-1:0]      cnt;
    logic [FILT_W-1:0]      cnt_next;
    logic                   iq_reg;

    assign din  = PAD_IN & IE;
    assign sync = sync_q[SYNC_STAGES-1];

    // Any sample matching filt restarts the count; a new level is accepted on the
    // FILT_LEN-th consecutive differing sample.
    always_comb begin
        filt_next = filt;
        cnt_next  = '0;
        if (!FILT_EN) begin
            filt_next = sync;
        end else if (sync != filt) begin
            if (cnt == FILT_W'(FILT_LEN - 1))
                filt_next = sync;
            else
                cnt_next = cnt + FILT_W'(1);
        end
    end

    always_ff @(posedge IQC or negedge QRN) begin
        if (!QRN) begin
            sync_q   <= '0;
            filt     <= 1'b0;
            cnt      <= '0;
            iq_reg   <= 1'b0;
            RISE     <= 1'b0;
            FALL     <= 1'b0;
            EDGE_STS <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            filt   <= filt_next;
            cnt    <= cnt_next;
            RISE   <= filt_next & ~filt;
            FALL   <= ~filt_next & filt;
            if (IQE)
                iq_reg <= filt_next;
            // Set has priority over clear when both occur in one cycle.
            if (filt_next != filt)
                EDGE_STS <= 1'b1;
            else if (CLR)
                EDGE_STS <= 1'b0;
        end
    end

    assign A2F_OUT = ISEL ? iq_reg : din;

endmodule

// File: tb/tb_io_in_capture_cell.sv
// Directed self-checking bench for io_in_capture_cell at default parameters.
module tb_io_in_capture_cell;

    logic IQC = 1'b0;
    logic QRN, PAD_IN, IE, ISEL, IQE, FILT_EN, CLR;
    logic A2F_OUT, RISE, FALL, EDGE_STS;
    int errors = 0;
    int checks = 0;

    io_in_capture_cell #(.SYNC_STAGES(2), .FILT_LEN(4), .FILT_W(4)) dut (
        .IQC(IQC), .QRN(QRN), .PAD_IN(PAD_IN), .IE(IE), .ISEL(ISEL), .IQE(IQE),
        .FILT_EN(FILT_EN), .CLR(CLR), .A2F_OUT(A2F_OUT), .RISE(RISE), .FALL(FALL),
        .EDGE_STS(EDGE_STS)
    );

    always #5 IQC = ~IQC;

    task automatic step();
        @(posedge IQC);
        #1;
    endtask

    task automatic test_reset();
        QRN = 1'b0; PAD_IN = 1'b1; IE = 1'b1; ISEL = 1'b1; IQE = 1'b1;
        FILT_EN = 1'b1; CLR = 1'b0;
        #12;
        checks++;
        if ({A2F_OUT, RISE, FALL, EDGE_STS} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0000", {A2F_OUT, RISE, FALL, EDGE_STS});
        end
        step();
        QRN = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (RISE !== (k == 6)) begin
                errors++; $display("FAIL reset_rise edge=%0d got=%b exp=%b", k, RISE, k == 6);
            end
            checks++;
            if (A2F_OUT !== (k >= 6)) begin
                errors++; $display("FAIL reset_a2f edge=%0d got=%b exp=%b", k, A2F_OUT, k >= 6);
            end
        end
        checks++;
        if (EDGE_STS !== 1'b1) begin
            errors++; $display("FAIL reset_sts got=%b exp=1", EDGE_STS);
        end
    endtask

    task automatic glitch_run(input int high_cycles, input int rise_at, input int fall_at, input string nm);
        int rises = 0;
        int falls = 0;
        PAD_IN = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == high_cycles) PAD_IN = 1'b0;
            if (RISE === 1'b1) rises++;
            if (FALL === 1'b1) falls++;
            checks++;
            if (RISE !== (k == rise_at) || FALL !== (k == fall_at)) begin
                errors++;
                $display("FAIL %s edge=%0d got rise=%b fall=%b exp rise=%b fall=%b",
                         nm, k, RISE, FALL, k == rise_at, k == fall_at);
            end
            if (k < 4) begin
                checks++;
                if (A2F_OUT !== 1'b0) begin
                    errors++; $display("FAIL %s_a2f edge=%0d got=%b exp=0", nm, k, A2F_OUT);
                end
            end
        end
        checks++;
        if (rises !== (rise_at > 0 ? 1 : 0) || falls !== (fall_at > 0 ? 1 : 0)) begin
            errors++; $display("FAIL %s_count got rises=%0d falls=%0d", nm, rises, falls);
        end
    endtask

    task automatic test_glitch();
        PAD_IN = 1'b0;
        for (int k = 0; k < 10; k++) step();
        CLR = 1'b1; step(); CLR = 1'b0;
        checks++;
        if (EDGE_STS !== 1'b0) begin
            errors++; $display("FAIL glitch_clr got=%b exp=0", EDGE_STS);
        end
        glitch_run(3, 0, 0, "glitch3");
        checks++;
        if (EDGE_STS !== 1'b0 || A2F_OUT !== 1'b0) begin
            errors++; $display("FAIL glitch3_state got sts=%b a2f=%b exp 0 0", EDGE_STS, A2F_OUT);
        end
        glitch_run(4, 6, 10, "glitch4");
        checks++;
        if (EDGE_STS !== 1'b1) begin
            errors++; $display("FAIL glitch4_sts got=%b exp=1", EDGE_STS);
        end
    endtask

    task automatic test_filter_bypass();
        FILT_EN = 1'b0;
        PAD_IN = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) PAD_IN = 1'b0;
            checks++;
            if (RISE !== (k == 3) || FALL !== (k == 4)) begin
                errors++;
                $display("FAIL bypass_pulse edge=%0d got rise=%b fall=%b exp rise=%b fall=%b",
                         k, RISE, FALL, k == 3, k == 4);
            end
        end
        FILT_EN = 1'b1;
        PAD_IN = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 4) FILT_EN = 1'b0;
            checks++;
            if (RISE !== (k == 5) || FALL !== 1'b0) begin
                errors++;
                $display("FAIL toggle_pulse edge=%0d got rise=%b fall=%b exp rise=%b fall=0",
                         k, RISE, FALL, k == 5);
            end
        end
        FILT_EN = 1'b1;
    endtask

    task automatic test_capture();
        IQE = 1'b0;
        PAD_IN = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (A2F_OUT !== 1'b1 || FALL !== (k == 6)) begin
                errors++;
                $display("FAIL capture_hold edge=%0d got a2f=%b fall=%b exp a2f=1 fall=%b",
                         k, A2F_OUT, FALL, k == 6);
            end
        end
        ISEL = 1'b0;
        PAD_IN = 1'b1; #1;
        checks++;
        if (A2F_OUT !== 1'b1) begin
            errors++; $display("FAIL bypass_hi got=%b exp=1", A2F_OUT);
        end
        PAD_IN = 1'b0; #1;
        checks++;
        if (A2F_OUT !== 1'b0) begin
            errors++; $display("FAIL bypass_lo got=%b exp=0", A2F_OUT);
        end
        IE = 1'b0; PAD_IN = 1'b1; #1;
        checks++;
        if (A2F_OUT !== 1'b0) begin
            errors++; $display("FAIL bypass_ie got=%b exp=0", A2F_OUT);
        end
        IE = 1'b1; PAD_IN = 1'b0; ISEL = 1'b1; IQE = 1'b1;
        step(); step();
        checks++;
        if (A2F_OUT !== 1'b0) begin
            errors++; $display("FAIL capture_reload got=%b exp=0", A2F_OUT);
        end
    endtask

    task automatic test_sticky();
        CLR = 1'b1; step(); CLR = 1'b0;
        checks++;
        if (EDGE_STS !== 1'b0) begin
            errors++; $display("FAIL sticky_clr got=%b exp=0", EDGE_STS);
        end
        FILT_EN = 1'b0;
        PAD_IN = 1'b1;
        step(); step();
        CLR = 1'b1;
        step();
        checks++;
        if (RISE !== 1'b1 || EDGE_STS !== 1'b1) begin
            errors++; $display("FAIL sticky_set_wins got rise=%b sts=%b exp 1 1", RISE, EDGE_STS);
        end
        step();
        checks++;
        if (EDGE_STS !== 1'b0) begin
            errors++; $display("FAIL sticky_clr_later got=%b exp=0", EDGE_STS);
        end
        CLR = 1'b0;
        FILT_EN = 1'b1;
    endtask

    task automatic test_reset_mid();
        PAD_IN = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        checks++;
        if (dut.cnt !== 4'd3 || dut.filt !== 1'b1) begin
            errors++; $display("FAIL midreset_setup got cnt=%0d filt=%b exp 3 1", dut.cnt, dut.filt);
        end
        #2;
        QRN = 1'b0;
        #1;
        checks++;
        if ({A2F_OUT, RISE, FALL, EDGE_STS, dut.filt} !== 5'b00000 || dut.cnt !== 4'd0) begin
            errors++;
            $display("FAIL midreset_clear got a2f/rise/fall/sts/filt=%b cnt=%0d exp 00000 0",
                     {A2F_OUT, RISE, FALL, EDGE_STS, dut.filt}, dut.cnt);
        end
        PAD_IN = 1'b1;
        step();
        QRN = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (RISE !== (k == 6) || FALL !== 1'b0) begin
                errors++;
                $display("FAIL midreset_rise edge=%0d got rise=%b fall=%b exp rise=%b fall=0",
                         k, RISE, FALL, k == 6);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_filter_bypass();
        test_capture();
        test_sticky();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
